mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory stage directly downstream of the execute-stage ALU.
- Consumes the ALU result (the effective address for loads and stores), the 8-bit ALU operation code, store data and the destination register.
- Runs the data-memory request/response handshake, then aligns and sign/zero-extends load data.
- Presents one registered result per instruction to writeback; non-memory ops pass through with the ALU result.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT_RSP before abort; 0 disables the timeout.
- ADDR_W, 32: data-memory address width.

Ports:
- clk  in  1  stage clock
- rst  in  1  reset; synchronous, active-high
- ex_valid  in  1  execute output valid
- ex_ready  out  1  unit can accept an instruction this cycle
- ex_op  in  8  ALU operation code (ALU_OPERATIONS_* encoding)
- ex_result  in  32  ALU result / effective address
- ex_store_data  in  32  rs2 value for stores
- ex_rd  in  5  destination register
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_req_we  out  1  1 = store
- dmem_req_wstrb  out  4  byte-lane strobes
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_rsp_valid  in  1  read data valid (loads only)
- dmem_rsp_rdata  in  32  read word
- wb_valid  out  1  writeback entry valid
- wb_ready  in  1  writeback consumes entry
- wb_data  out  32  result to register file
- wb_rd  out  5  destination register
- wb_we  out  1  register-file write enable (0 for stores, faults, rd = 0)
- mem_fault  out  1  one-cycle pulse: misaligned access or timeout
- fault_addr  out  32  effective address of the faulting access

Behaviour:
- Reset (rst high at a clk edge): FSM enters IDLE from any state, abandoning any outstanding request.
  - All outputs 0.
  - ex_ready is 1 in the first cycle after reset.
  - A dmem response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT_RSP, WB.
- Acceptance: in IDLE, ex_ready = 1; an instruction is accepted when ex_valid && ex_ready. All fields are captured; ex_ready is 0 in every other state.
- Non-memory op (anything except LB/LH/LW/LBU/LHU/SB/SH/SW):
  - IDLE -> WB.
  - wb_data = ex_result; wb_we = (rd != 0).
  - Latency: 1 cycle from acceptance to wb_valid.
- Load/store:
  - IDLE -> REQ.
  - REQ holds dmem_req_* stable with dmem_req_valid = 1 until dmem_req_ready.
  - Store: REQ -> WB on handshake; wb_we = 0.
  - Load: REQ -> WAIT_RSP on handshake; WAIT_RSP -> WB on dmem_rsp_valid.
  - Responses seen in REQ or IDLE are ignored.
- Store strobes, with a = addr[1:0]:
  - SB: wstrb = 1 << a; wdata = {4{data[7:0]}}.
  - SH: wstrb = 0011 (a = 0) or 1100 (a = 2); wdata = {2{data[15:0]}}.
  - SW: wstrb = 1111.
- Load extraction:
  - LB/LBU: byte at rdata[8a+7:8a], sign- or zero-extended.
  - LH/LHU: half at rdata[16(a>>1)+15 : 16(a>>1)], sign- or zero-extended.
  - LW: full word.
- WB: wb_valid = 1 and wb_* held stable until wb_ready. On wb_valid && wb_ready, WB -> IDLE, so back-to-back instructions cost at least 2 cycles each.
- Timeout:
  - The counter counts cycles in WAIT_RSP and is cleared on entry.
  - At TIMEOUT_CYCLES: pulse mem_fault, fault_addr = address, go to WB with wb_we = 0 and wb_data = 0.
- Throughput: one instruction in flight; no request pipelining.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned LH/LHU/SH (a[0] = 1) or LW/SW (a != 0) issues no dmem request.
  - IDLE -> WB directly; mem_fault pulses that cycle; fault_addr = effective address; wb_we = 0.
- Undefined:
  - Low address bits are forced aligned: halfword uses a[1] only, word uses a = 0.
  - mem_fault asserts only on timeout.

Decomposition:
- Shared package mem_pkg:
  - mem_state_t enum (IDLE/REQ/WAIT_RSP/WB).
  - mem_size_t (BYTE/HALF/WORD) and an is_mem_op()/is_load() helper keyed on the existing ALU_OPERATIONS_* defines.
- One combinational sub-module, load_store_align: strobe/wdata generation and load extraction/extension. It is separately unit-testable.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, dmem_req_ready held low 3 cycles -> req fields stable for all 4 cycles; wstrb = 1111; wb_we = 0.
- LB addr 0x103, rdata 0x80FF_1234 -> wb_data = 0xFFFFFF80. LBU same -> 0x00000080.
- SH addr 0x202, data 0x0000ABCD -> wstrb = 1100, wdata = 0xABCDABCD. LHU addr 0x202, rdata 0xABCD0000 -> 0x0000ABCD.
- ADD result 0x55 with rd = 0, wb_ready low 2 cycles -> wb_valid for 3 cycles, wb_we = 0, ex_ready low throughout.
- LW with no response, TIMEOUT_CYCLES = 4 -> mem_fault pulse in the 4th WAIT_RSP cycle, then wb_valid with wb_we = 0. Assert rst in WAIT_RSP -> IDLE next cycle, outputs 0, a late dmem_rsp_valid is ignored.
- LW addr 0x101 -> with MEM_ACCESS_MISALIGN_TRAP_EN: no dmem_req_valid, mem_fault = 1, fault_addr = 0x101. Without: request to 0x100.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage.
// ALU_OPERATIONS_* codes come from the ALU's define set; fallbacks are
// provided so this slice compiles on its own.
// Contents: mem_state_t (FSM states), mem_size_t (access width),
// OP_* opcode constants, is_mem_op / is_load / op_size / is_unsigned_load.
`ifndef ALU_OPERATIONS_ADD
`define ALU_OPERATIONS_ADD 8'h00
`endif
`ifndef ALU_OPERATIONS_LB
`define ALU_OPERATIONS_LB 8'h10
`endif
`ifndef ALU_OPERATIONS_LH
`define ALU_OPERATIONS_LH 8'h11
`endif
`ifndef ALU_OPERATIONS_LW
`define ALU_OPERATIONS_LW 8'h12
`endif
`ifndef ALU_OPERATIONS_LBU
`define ALU_OPERATIONS_LBU 8'h14
`endif
`ifndef ALU_OPERATIONS_LHU
`define ALU_OPERATIONS_LHU 8'h15
`endif
`ifndef ALU_OPERATIONS_SB
`define ALU_OPERATIONS_SB 8'h18
`endif
`ifndef ALU_OPERATIONS_SH
`define ALU_OPERATIONS_SH 8'h19
`endif
`ifndef ALU_OPERATIONS_SW
`define ALU_OPERATIONS_SW 8'h1A
`endif

package mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, WB} mem_state_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;

  localparam logic [7:0] OP_ADD = `ALU_OPERATIONS_ADD;
  localparam logic [7:0] OP_LB  = `ALU_OPERATIONS_LB;
  localparam logic [7:0] OP_LH  = `ALU_OPERATIONS_LH;
  localparam logic [7:0] OP_LW  = `ALU_OPERATIONS_LW;
  localparam logic [7:0] OP_LBU = `ALU_OPERATIONS_LBU;
  localparam logic [7:0] OP_LHU = `ALU_OPERATIONS_LHU;
  localparam logic [7:0] OP_SB  = `ALU_OPERATIONS_SB;
  localparam logic [7:0] OP_SH  = `ALU_OPERATIONS_SH;
  localparam logic [7:0] OP_SW  = `ALU_OPERATIONS_SW;

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_load(op) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_unsigned_load(input logic [7:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic mem_size_t op_size(input logic [7:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return BYTE;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return HALF;
    return WORD;
  endfunction
endpackage

// File: rtl/mem_access_unit_align.sv
// load_store_align: purely combinational byte-lane logic.
// Ports: size (mem_size_t encoding), unsigned_ld, offset (addr[1:0]),
//   store_data, rdata in; wstrb, wdata (lane-replicated), load_data
//   (extracted and extended) out.
// Halfword accesses use offset[1] only and word accesses ignore offset,
// so low address bits are effectively forced aligned.
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  mem_size_t   sz;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign sz = mem_size_t'(size);

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb     = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (sz)
      BYTE: begin
        wstrb     = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7] & ~unsigned_ld}}, byte_sel};
      end
      HALF: begin
        wstrb     = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_sel[15] & ~unsigned_ld}}, half_sel};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage after the execute ALU. Accepts one
// instruction at a time, runs the dmem request/response handshake for
// loads/stores, aligns load data and presents one result to writeback.
// Ports: clk/rst (sync, active-high); ex_* accept side (valid/ready, op,
//   result/address, store data, rd); dmem_req_* request channel;
//   dmem_rsp_* read response; wb_* writeback entry; mem_fault/fault_addr.
// Params: TIMEOUT_CYCLES (0 = no timeout), ADDR_W.
// Build option: MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned half/word
//   accesses instead of forcing them aligned.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [7:0]        ex_op,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic              dmem_req_we,
  output logic [3:0]        dmem_req_wstrb,
  output logic [31:0]       dmem_req_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rsp_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic              mem_fault,
  output logic [31:0]       fault_addr
);
  mem_state_t  state_q, state_d;
  logic [7:0]  op_q;
  logic [31:0] addr_q, sdata_q, cnt_q;
  logic [4:0]  rd_q;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_we_q, wb_we_d, load_wb;
  logic        misalign, timeout_hit, store_q;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;

  load_store_align u_align (
    .size       (op_size(op_q)),
    .unsigned_ld(is_unsigned_load(op_q)),
    .offset     (addr_q[1:0]),
    .store_data (sdata_q),
    .rdata      (dmem_rsp_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  // Misalignment is judged on the incoming instruction so a trapped access
  // never reaches REQ.
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misalign = is_mem_op(ex_op) &&
                    ((op_size(ex_op) == HALF && ex_result[0]) ||
                     (op_size(ex_op) == WORD && ex_result[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign store_q     = !is_load(op_q);
  // Counter reads 0 in the first WAIT_RSP cycle, so the fault fires in
  // cycle number TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ex_valid) begin
        op_q    <= ex_op;
        addr_q  <= ex_result;
        sdata_q <= ex_store_data;
        rd_q    <= ex_rd;
      end
      cnt_q <= (state_q == WAIT_RSP) ? cnt_q + 32'd1 : '0;
      if (load_wb) begin
        wb_data_q <= wb_data_d;
        wb_we_q   <= wb_we_d;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ex_ready       = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_we    = 1'b0;
    dmem_req_wstrb = '0;
    dmem_req_wdata = '0;
    wb_valid       = 1'b0;
    wb_data        = '0;
    wb_rd          = '0;
    wb_we          = 1'b0;
    mem_fault      = 1'b0;
    fault_addr     = '0;
    load_wb        = 1'b0;
    wb_data_d      = '0;
    wb_we_d        = 1'b0;
    case (state_q)
      IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid) begin
          if (!is_mem_op(ex_op)) begin
            state_d   = WB;
            load_wb   = 1'b1;
            wb_data_d = ex_result;
            wb_we_d   = (ex_rd != 5'd0);
          end else if (misalign) begin
            state_d    = WB;
            load_wb    = 1'b1;
            mem_fault  = 1'b1;
            fault_addr = ex_result;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        dmem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        dmem_req_we    = store_q;
        dmem_req_wstrb = store_q ? al_wstrb : 4'b0000;
        dmem_req_wdata = store_q ? al_wdata : 32'd0;
        if (dmem_req_ready) begin
          if (store_q) begin
            state_d = WB;
            load_wb = 1'b1;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          state_d   = WB;
          load_wb   = 1'b1;
          wb_data_d = al_load;
          wb_we_d   = (rd_q != 5'd0);
        end else if (timeout_hit) begin
          state_d    = WB;
          load_wb    = 1'b1;
          mem_fault  = 1'b1;
          fault_addr = addr_q;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        wb_data  = wb_data_q;
        wb_rd    = rd_q;
        wb_we    = wb_we_q;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [7:0]  ex_op;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        wb_valid, wb_ready, wb_we;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        mem_fault;
  logic [31:0] fault_addr;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we),
    .mem_fault(mem_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic we);
    wb_exp_t e;
    e.data = d; e.rd = rd; e.we = we;
    sb.push_back(e);
  endtask

  // Drive one instruction for a single accepted cycle.
  task automatic issue(input logic [7:0] op, input logic [31:0] res,
                       input logic [31:0] sd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_op = op; ex_result = res; ex_store_data = sd; ex_rd = rd;
    #1;
    check("ex_ready_accept", 32'(ex_ready), 32'd1);
    step();
    ex_valid = 1'b0;
  endtask

  task automatic mem_store(input string tag, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] wd);
    dmem_req_ready = 1'b1;
    #1;
    check({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
    check({tag, "_addr"}, dmem_req_addr, addr);
    check({tag, "_we"}, 32'(dmem_req_we), 32'd1);
    check({tag, "_wstrb"}, 32'(dmem_req_wstrb), 32'(strb));
    check({tag, "_wdata"}, dmem_req_wdata, wd);
    step();
    dmem_req_ready = 1'b0;
  endtask

  task automatic mem_load(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
    dmem_req_ready = 1'b1;
    #1;
    check({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
    check({tag, "_addr"}, dmem_req_addr, addr);
    check({tag, "_we"}, 32'(dmem_req_we), 32'd0);
    step();
    dmem_req_ready = 1'b0;
    step();  // one idle cycle in WAIT_RSP
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rdata;
    step();
    dmem_rsp_valid = 1'b0; dmem_rsp_rdata = 32'h0;
  endtask

  // Wait (bounded) for a writeback entry, compare it against the scoreboard.
  task automatic wait_wb(input string tag);
    wb_exp_t e;
    int n;
    n = 0;
    #1;
    while (!wb_valid && n < 40) begin
      step(); #1; n++;
    end
    if (!wb_valid) begin
      n_cmp++; n_err++;
      $error("FAIL %s_wb_timeout: observed wb_valid=0 expected 1", tag);
    end else if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s_wb_unexpected: observed entry expected none", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_wb_data"}, wb_data, e.data);
      check({tag, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
      check({tag, "_wb_we"}, 32'(wb_we), 32'(e.we));
      check({tag, "_ex_ready_busy"}, 32'(ex_ready), 32'd0);
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
  endtask

  initial begin
    wb_exp_t e;
    rst = 1'b1; ex_valid = 1'b0; ex_op = 8'h0; ex_result = 32'h0;
    ex_store_data = 32'h0; ex_rd = 5'd0; dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0; dmem_rsp_rdata = 32'h0; wb_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_fault", 32'(mem_fault), 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);

    // SW with request stalled 3 cycles: fields must hold for all 4 cycles.
    push(32'h0, 5'd3, 1'b0);
    issue(OP_SW, 32'h100, 32'hDEADBEEF, 5'd3);
    for (int i = 0; i < 4; i++) begin
      dmem_req_ready = (i == 3);
      #1;
      check("sw_req_valid", 32'(dmem_req_valid), 32'd1);
      check("sw_addr", dmem_req_addr, 32'h100);
      check("sw_we", 32'(dmem_req_we), 32'd1);
      check("sw_wstrb", 32'(dmem_req_wstrb), 32'hF);
      check("sw_wdata", dmem_req_wdata, 32'hDEADBEEF);
      check("sw_ex_ready", 32'(ex_ready), 32'd0);
      step();
    end
    dmem_req_ready = 1'b0;
    wait_wb("sw");

    // Byte loads from lane 3, signed and unsigned.
    push(32'hFFFFFF80, 5'd5, 1'b1);
    issue(OP_LB, 32'h103, 32'h0, 5'd5);
    mem_load("lb", 32'h100, 32'h80FF1234);
    wait_wb("lb");
    push(32'h00000080, 5'd6, 1'b1);
    issue(OP_LBU, 32'h103, 32'h0, 5'd6);
    mem_load("lbu", 32'h100, 32'h80FF1234);
    wait_wb("lbu");

    // Halfword store to upper half, halfword loads both halves.
    push(32'h0, 5'd7, 1'b0);
    issue(OP_SH, 32'h202, 32'h0000ABCD, 5'd7);
    mem_store("sh", 32'h200, 4'b1100, 32'hABCDABCD);
    wait_wb("sh");
    push(32'h0000ABCD, 5'd8, 1'b1);
    issue(OP_LHU, 32'h202, 32'h0, 5'd8);
    mem_load("lhu", 32'h200, 32'hABCD0000);
    wait_wb("lhu");
    push(32'hFFFF8001, 5'd8, 1'b1);
    issue(OP_LH, 32'h200, 32'h0, 5'd8);
    mem_load("lh", 32'h200, 32'h12348001);
    wait_wb("lh");

    // Byte store lane 1, word load.
    push(32'h0, 5'd2, 1'b0);
    issue(OP_SB, 32'h101, 32'h00000077, 5'd2);
    mem_store("sb", 32'h100, 4'b0010, 32'h77777777);
    wait_wb("sb");
    push(32'hCAFEF00D, 5'd31, 1'b1);
    issue(OP_LW, 32'h104, 32'h0, 5'd31);
    mem_load("lw", 32'h104, 32'hCAFEF00D);
    wait_wb("lw");

    // ADD to rd=0 with writeback stalled 2 cycles.
    push(32'h55, 5'd0, 1'b0);
    issue(OP_ADD, 32'h55, 32'h0, 5'd0);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      wb_ready = (i == 2);
      #1;
      check("add_wb_valid", 32'(wb_valid), 32'd1);
      check("add_wb_data", wb_data, e.data);
      check("add_wb_we", 32'(wb_we), 32'(e.we));
      check("add_ex_ready", 32'(ex_ready), 32'd0);
      step();
    end
    wb_ready = 1'b0;
    #1;
    check("add_done_wb_valid", 32'(wb_valid), 32'd0);
    check("add_done_ex_ready", 32'(ex_ready), 32'd1);

    // Non-memory op with rd != 0 writes back.
    push(32'h00001234, 5'd9, 1'b1);
    issue(OP_ADD, 32'h1234, 32'h0, 5'd9);
    wait_wb("add_rd9");

    // LW with no response: fault in the 4th WAIT_RSP cycle.
    push(32'h0, 5'd9, 1'b0);
    issue(OP_LW, 32'h300, 32'h0, 5'd9);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("to_mem_fault", 32'(mem_fault), (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) check("to_fault_addr", fault_addr, 32'h300);
      step();
    end
    #1;
    check("to_fault_cleared", 32'(mem_fault), 32'd0);
    wait_wb("timeout");

    // Reset while waiting for a response; late response ignored.
    issue(OP_LW, 32'h400, 32'h0, 5'd10);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rstw_ex_ready", 32'(ex_ready), 32'd1);
    check("rstw_req_valid", 32'(dmem_req_valid), 32'd0);
    check("rstw_wb_valid", 32'(wb_valid), 32'd0);
    check("rstw_mem_fault", 32'(mem_fault), 32'd0);
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h99999999;
    step();
    dmem_rsp_valid = 1'b0;
    #1;
    check("late_rsp_wb_valid", 32'(wb_valid), 32'd0);
    check("late_rsp_ex_ready", 32'(ex_ready), 32'd1);
    step();

    // Misaligned word load.
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    push(32'h0, 5'd11, 1'b0);
    ex_valid = 1'b1; ex_op = OP_LW; ex_result = 32'h101; ex_rd = 5'd11;
    #1;
    check("mis_mem_fault", 32'(mem_fault), 32'd1);
    check("mis_fault_addr", fault_addr, 32'h101);
    check("mis_req_valid", 32'(dmem_req_valid), 32'd0);
    step();
    ex_valid = 1'b0;
    #1;
    check("mis_req_valid_after", 32'(dmem_req_valid), 32'd0);
    wait_wb("mis");
`else
    push(32'h11223344, 5'd11, 1'b1);
    ex_valid = 1'b1; ex_op = OP_LW; ex_result = 32'h101; ex_rd = 5'd11;
    #1;
    check("mis_no_fault", 32'(mem_fault), 32'd0);
    step();
    ex_valid = 1'b0;
    mem_load("mis", 32'h100, 32'h11223344);
    wait_wb("mis");
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
